// File: rtl/miss_repair_engine_pkg.sv
// Shared widths, FSM encoding and request payload for the MSHR miss repair engine.
package miss_repair_engine_pkg;

  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned WORD_OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned LINE_OFF_W = WORD_OFF_W + 2;
  localparam int unsigned LINE_W     = LINE_WORDS * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_FILL,
    ST_DONE
  } repair_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_st;
    logic [DATA_W-1:0] st_data;
    logic [IDX_W-1:0]  idx;
  } repair_req_t;

  // Clear the byte-in-line offset so the address points at word 0 of the line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/miss_repair_engine_if.sv
// MSHR request, memory port, cache fill and completion signals of the repair engine.
interface miss_repair_engine_if;
  import miss_repair_engine_pkg::*;

  logic              repair_req_valid;
  logic              repair_req_ready;
  logic [ADDR_W-1:0] repair_req_addr;
  logic              repair_req_is_st;
  logic [DATA_W-1:0] repair_req_st_data;
  logic [IDX_W-1:0]  repair_req_idx;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic              repair_complete;
  logic [IDX_W-1:0]  repair_idx;
  logic              busy;

  modport slave (
    input  repair_req_valid, repair_req_addr, repair_req_is_st, repair_req_st_data,
           repair_req_idx, mem_req_ready, mem_resp_valid, mem_resp_data,
    output repair_req_ready, mem_req_valid, mem_req_addr, fill_we, fill_addr, fill_data,
           repair_complete, repair_idx, busy
  );

  modport master (
    output repair_req_valid, repair_req_addr, repair_req_is_st, repair_req_st_data,
           repair_req_idx, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  repair_req_ready, mem_req_valid, mem_req_addr, fill_we, fill_addr, fill_data,
           repair_complete, repair_idx, busy
  );

endinterface

// File: rtl/miss_repair_engine_line_fill_buffer.sv
// Line buffer written one beat at a time, with the store word merged on the read side.
module miss_repair_engine_line_fill_buffer
  import miss_repair_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [WORD_OFF_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  merge_en_i,
  input  logic [WORD_OFF_W-1:0] merge_idx_i,
  input  logic [DATA_W-1:0]     merge_data_i,
  output logic [LINE_W-1:0]     line_o
);

  logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0] merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (wr_en_i) begin
      line_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    merged = line_q;
    if (merge_en_i) begin
      merged[merge_idx_i] = merge_data_i;
    end
  end

  assign line_o = merged;

endmodule

// File: rtl/miss_repair_engine.sv
// Fetches a missing line for one MSHR entry, merges a pending store word, fills the cache.
module miss_repair_engine
  import miss_repair_engine_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  miss_repair_engine_if.slave bus
);

  repair_state_e         state_q, state_d;
  repair_req_t           req_q, req_d;
  logic [WORD_OFF_W-1:0] cnt_q, cnt_d;
  logic                  beat_we;
  logic [LINE_W-1:0]     line;
  logic                  unused_addr_lsb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    beat_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.repair_req_valid) begin
          req_d = '{addr:    bus.repair_req_addr,
                    is_st:   bus.repair_req_is_st,
                    st_data: bus.repair_req_st_data,
                    idx:     bus.repair_req_idx};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        // Counter wraps to 0 naturally on the final beat.
        if (bus.mem_resp_valid) begin
          beat_we = 1'b1;
          cnt_d   = cnt_q + WORD_OFF_W'(1);
          if (cnt_q == WORD_OFF_W'(LINE_WORDS - 1)) begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  miss_repair_engine_line_fill_buffer u_lfb (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (beat_we),
    .wr_idx_i     (cnt_q),
    .wr_data_i    (bus.mem_resp_data),
    .merge_en_i   (req_q.is_st),
    .merge_idx_i  (req_q.addr[LINE_OFF_W-1:2]),
    .merge_data_i (req_q.st_data),
    .line_o       (line)
  );

  // Store merge is full-word, so the byte offset is intentionally dropped.
  assign unused_addr_lsb = ^req_q.addr[1:0];

  assign bus.repair_req_ready = (state_q == ST_IDLE);
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.mem_req_valid    = (state_q == ST_REQ);
  assign bus.mem_req_addr     = (state_q == ST_REQ)  ? line_align(req_q.addr) : '0;
  assign bus.fill_we          = (state_q == ST_FILL);
  assign bus.fill_addr        = (state_q == ST_FILL) ? line_align(req_q.addr) : '0;
  assign bus.fill_data        = (state_q == ST_FILL) ? line : '0;
  assign bus.repair_complete  = (state_q == ST_DONE);
  assign bus.repair_idx       = (state_q == ST_DONE) ? req_q.idx : '0;

endmodule

// File: tb/tb_miss_repair_engine.sv
// Directed bench for miss_repair_engine: load/store repairs, stalls, gaps, reset abort, back-to-back.
module tb_miss_repair_engine;
  import miss_repair_engine_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   fill_cnt;
  int   done_cnt;
  bit   allow_stray;

  miss_repair_engine_if bus_if ();

  miss_repair_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responses may only arrive while the engine is collecting beats.
  always @(posedge clk) begin
    if (!rst && !allow_stray && bus_if.mem_resp_valid) begin
      assert (bus_if.busy && !bus_if.mem_req_valid && !bus_if.fill_we && !bus_if.repair_complete)
        else $error("FAIL protocol: mem_resp_valid outside RECV");
    end
  end

  always @(negedge clk) begin
    if (bus_if.fill_we) fill_cnt++;
    if (bus_if.repair_complete) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d);
    bus_if.mem_resp_valid = 1'b1;
    bus_if.mem_resp_data  = d;
    tick();
    bus_if.mem_resp_valid = 1'b0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] a, input logic st, input logic [DATA_W-1:0] sd,
                       input logic [IDX_W-1:0] ix);
    bus_if.repair_req_valid   = 1'b1;
    bus_if.repair_req_addr    = a;
    bus_if.repair_req_is_st   = st;
    bus_if.repair_req_st_data = sd;
    bus_if.repair_req_idx     = ix;
    tick();
    bus_if.repair_req_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (bus_if.repair_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus_if.repair_req_ready); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus_if.busy); end
    checks++; if (bus_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %0b want 0", bus_if.mem_req_valid); end
    checks++; if (bus_if.fill_we !== 1'b0 || bus_if.fill_data !== '0) begin errors++; $display("FAIL reset_fill: we %0b data %h want 0", bus_if.fill_we, bus_if.fill_data); end
    checks++; if (bus_if.repair_complete !== 1'b0 || bus_if.repair_idx !== '0) begin errors++; $display("FAIL reset_complete: got %0b idx %0d want 0", bus_if.repair_complete, bus_if.repair_idx); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_miss();
    bus_if.mem_req_ready = 1'b1;
    issue(32'h0000_1234, 1'b0, 32'h0, 3'd2);
    checks++; if (bus_if.mem_req_valid !== 1'b1 || bus_if.mem_req_addr !== 32'h0000_1230) begin errors++; $display("FAIL load_mem_req: valid %0b addr %h want 1 00001230", bus_if.mem_req_valid, bus_if.mem_req_addr); end
    checks++; if (bus_if.repair_req_ready !== 1'b0 || bus_if.busy !== 1'b1) begin errors++; $display("FAIL load_busy: ready %0b busy %0b want 0 1", bus_if.repair_req_ready, bus_if.busy); end
    tick();
    for (int i = 0; i < 4; i++) beat(32'hA0 + 32'(i));
    checks++; if (bus_if.fill_we !== 1'b1 || bus_if.fill_addr !== 32'h0000_1230) begin errors++; $display("FAIL load_fill_we: we %0b addr %h want 1 00001230", bus_if.fill_we, bus_if.fill_addr); end
    checks++; if (bus_if.fill_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL load_fill_data: got %h", bus_if.fill_data); end
    checks++; if (bus_if.repair_complete !== 1'b0) begin errors++; $display("FAIL load_early_complete: got %0b want 0", bus_if.repair_complete); end
    tick();
    checks++; if (bus_if.repair_complete !== 1'b1 || bus_if.repair_idx !== 3'd2 || bus_if.fill_we !== 1'b0) begin errors++; $display("FAIL load_complete: done %0b idx %0d we %0b want 1 2 0", bus_if.repair_complete, bus_if.repair_idx, bus_if.fill_we); end
    tick();
    checks++; if (bus_if.repair_req_ready !== 1'b1 || bus_if.repair_complete !== 1'b0) begin errors++; $display("FAIL load_idle: ready %0b done %0b want 1 0", bus_if.repair_req_ready, bus_if.repair_complete); end
  endtask

  task automatic test_store_miss();
    bus_if.mem_req_ready = 1'b1;
    issue(32'h0000_2008, 1'b1, 32'hDEAD_BEEF, 3'd5);
    tick();
    for (int i = 0; i < 4; i++) beat(32'(i));
    checks++; if (bus_if.fill_we !== 1'b1 || bus_if.fill_addr !== 32'h0000_2000) begin errors++; $display("FAIL store_fill_addr: we %0b addr %h want 1 00002000", bus_if.fill_we, bus_if.fill_addr); end
    checks++; if (bus_if.fill_data !== 128'h00000003_DEADBEEF_00000001_00000000) begin errors++; $display("FAIL store_merge: got %h", bus_if.fill_data); end
    tick();
    checks++; if (bus_if.repair_complete !== 1'b1 || bus_if.repair_idx !== 3'd5) begin errors++; $display("FAIL store_complete: done %0b idx %0d want 1 5", bus_if.repair_complete, bus_if.repair_idx); end
    tick();
  endtask

  task automatic test_req_stall();
    int f0;
    f0 = fill_cnt;
    bus_if.mem_req_ready = 1'b0;
    issue(32'h0000_3ABC, 1'b0, 32'h0, 3'd4);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus_if.mem_req_valid !== 1'b1 || bus_if.mem_req_addr !== 32'h0000_3AB0 || bus_if.fill_we !== 1'b0) begin errors++; $display("FAIL stall_hold_%0d: valid %0b addr %h we %0b want 1 00003ab0 0", i, bus_if.mem_req_valid, bus_if.mem_req_addr, bus_if.fill_we); end
      tick();
    end
    bus_if.mem_req_ready = 1'b1;
    tick();
    bus_if.mem_req_ready = 1'b0;
    checks++; if (bus_if.mem_req_valid !== 1'b0 || fill_cnt != f0) begin errors++; $display("FAIL stall_release: valid %0b fills %0d want 0 0", bus_if.mem_req_valid, fill_cnt - f0); end
    for (int i = 0; i < 4; i++) beat(32'h10 + 32'(i));
    checks++; if (bus_if.fill_we !== 1'b1 || bus_if.fill_data !== 128'h00000013_00000012_00000011_00000010) begin errors++; $display("FAIL stall_fill: we %0b data %h", bus_if.fill_we, bus_if.fill_data); end
    repeat (2) tick();
  endtask

  task automatic test_gaps();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int k;
    int f0;
    int d0;
    k  = 0;
    f0 = fill_cnt;
    d0 = done_cnt;
    bus_if.mem_req_ready = 1'b1;
    issue(32'h0000_7004, 1'b0, 32'h0, 3'd1);
    tick();
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        beat(32'hC0 + 32'(k));
        k++;
      end else begin
        bus_if.mem_resp_data = 32'hBAD0_0000;
        tick();
      end
    end
    checks++; if (bus_if.fill_we !== 1'b1 || bus_if.fill_data !== 128'h000000C3_000000C2_000000C1_000000C0) begin errors++; $display("FAIL gaps_fill: we %0b data %h", bus_if.fill_we, bus_if.fill_data); end
    repeat (3) tick();
    checks++; if (fill_cnt - f0 != 1 || done_cnt - d0 != 1) begin errors++; $display("FAIL gaps_once: fills %0d completes %0d want 1 1", fill_cnt - f0, done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int f0;
    int d0;
    bus_if.mem_req_ready = 1'b1;
    issue(32'h0000_4000, 1'b1, 32'h5555_5555, 3'd7);
    tick();
    beat(32'hE0);
    beat(32'hE1);
    f0 = fill_cnt;
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_if.repair_req_ready !== 1'b1 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: ready %0b busy %0b want 1 0", bus_if.repair_req_ready, bus_if.busy); end
    checks++; if (bus_if.mem_req_valid !== 1'b0 || bus_if.fill_we !== 1'b0 || bus_if.fill_data !== '0 || bus_if.repair_complete !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: mreq %0b we %0b data %h done %0b want 0", bus_if.mem_req_valid, bus_if.fill_we, bus_if.fill_data, bus_if.repair_complete); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    allow_stray = 1'b1;
    for (int i = 0; i < 4; i++) beat(32'hF0 + 32'(i));
    repeat (2) tick();
    allow_stray = 1'b0;
    checks++; if (fill_cnt != f0 || done_cnt != d0) begin errors++; $display("FAIL rstmid_stray: fills %0d completes %0d want 0 0", fill_cnt - f0, done_cnt - d0); end
    checks++; if (bus_if.repair_req_ready !== 1'b1 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: ready %0b busy %0b want 1 0", bus_if.repair_req_ready, bus_if.busy); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    bus_if.mem_req_ready      = 1'b1;
    bus_if.repair_req_valid   = 1'b1;
    bus_if.repair_req_addr    = 32'h0000_5000;
    bus_if.repair_req_is_st   = 1'b0;
    bus_if.repair_req_st_data = 32'h0;
    bus_if.repair_req_idx     = 3'd3;
    tick();
    bus_if.repair_req_addr    = 32'h0000_6010;
    bus_if.repair_req_is_st   = 1'b1;
    bus_if.repair_req_st_data = 32'h1234_5678;
    bus_if.repair_req_idx     = 3'd6;
    tick();
    for (int i = 0; i < 4; i++) beat(32'h30 + 32'(i));
    checks++; if (bus_if.fill_data !== 128'h00000033_00000032_00000031_00000030) begin errors++; $display("FAIL b2b_first_fill: got %h", bus_if.fill_data); end
    tick();
    checks++; if (bus_if.repair_complete !== 1'b1 || bus_if.repair_idx !== 3'd3 || bus_if.repair_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_done: done %0b idx %0d ready %0b want 1 3 0", bus_if.repair_complete, bus_if.repair_idx, bus_if.repair_req_ready); end
    tick();
    checks++; if (bus_if.repair_req_ready !== 1'b1 || bus_if.mem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready %0b mreq %0b want 1 0", bus_if.repair_req_ready, bus_if.mem_req_valid); end
    tick();
    bus_if.repair_req_valid = 1'b0;
    checks++; if (bus_if.mem_req_valid !== 1'b1 || bus_if.mem_req_addr !== 32'h0000_6010) begin errors++; $display("FAIL b2b_accept: mreq %0b addr %h want 1 00006010", bus_if.mem_req_valid, bus_if.mem_req_addr); end
    tick();
    for (int i = 0; i < 4; i++) beat(32'h20 + 32'(i));
    checks++; if (bus_if.fill_data !== 128'h00000023_00000022_00000021_12345678) begin errors++; $display("FAIL b2b_second_fill: got %h", bus_if.fill_data); end
    tick();
    checks++; if (bus_if.repair_complete !== 1'b1 || bus_if.repair_idx !== 3'd6) begin errors++; $display("FAIL b2b_second_done: done %0b idx %0d want 1 6", bus_if.repair_complete, bus_if.repair_idx); end
    repeat (4) tick();
    checks++; if (done_cnt - d0 != 2 || bus_if.busy !== 1'b0) begin errors++; $display("FAIL b2b_count: completes %0d busy %0b want 2 0", done_cnt - d0, bus_if.busy); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    fill_cnt    = 0;
    done_cnt    = 0;
    allow_stray = 1'b0;
    rst         = 1'b1;
    bus_if.repair_req_valid   = 1'b0;
    bus_if.repair_req_addr    = '0;
    bus_if.repair_req_is_st   = 1'b0;
    bus_if.repair_req_st_data = '0;
    bus_if.repair_req_idx     = '0;
    bus_if.mem_req_ready      = 1'b0;
    bus_if.mem_resp_valid     = 1'b0;
    bus_if.mem_resp_data      = '0;

    test_reset();
    test_load_miss();
    test_store_miss();
    test_req_stall();
    test_gaps();
    test_reset_mid();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/miss_repair_engine.md
Name: miss_repair_engine

Overview:
Responder side of the MSHR repair protocol. It accepts one repair request at a time from the MSHR and fetches the missing cache line from the memory interface, one word per beat. For store misses it merges the store word into the line, writes the line into the data cache, then pulses repair_complete so the MSHR marks the entry repaired. It sits between the MSHR/L1 data cache and the next-level memory port.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line (power of two, >=2)
ADDR_W, 32, address width
DATA_W, 32, word width
IDX_W, 3, width of MSHR entry index echoed back

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
repair_req_valid  in  1  MSHR presents a repair request
repair_req_ready  out  1  engine can accept a request (IDLE)
repair_req_addr  in  ADDR_W  miss address
repair_req_is_st  in  1  1: store miss, merge store data
repair_req_st_data  in  DATA_W  store word
repair_req_idx  in  IDX_W  MSHR entry index
mem_req_valid  out  1  line read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  line-aligned address
mem_resp_valid  in  1  one response beat valid
mem_resp_data  in  DATA_W  response word, ascending word order
fill_we  out  1  one-cycle cache line write strobe
fill_addr  out  ADDR_W  line-aligned fill address
fill_data  out  LINE_WORDS*DATA_W  merged line, word 0 in LSBs
repair_complete  out  1  one-cycle pulse: repair finished
repair_idx  out  IDX_W  entry index of completed repair, valid with repair_complete
busy  out  1  not IDLE

Behaviour:
- Reset (async assert, any state): state IDLE, beat counter 0, line buffer 0. repair_req_ready=1; all other outputs 0.
- FSM states: IDLE, REQ, RECV, FILL, DONE.
- IDLE: repair_req_ready=1, busy=0.
  - On valid&&ready: latch addr, is_st, st_data, idx; go to REQ.
  - mem_resp_valid in IDLE is ignored.
- REQ: mem_req_valid=1, mem_req_addr = latched addr with low log2(LINE_WORDS)+2 bits zeroed.
  - Address and valid stay stable until mem_req_ready.
  - On valid&&ready go to RECV with beat counter 0.
- RECV: each mem_resp_valid cycle writes mem_resp_data into buffer word [counter] and increments the counter.
  - On the beat where counter==LINE_WORDS-1, go to FILL.
  - Gaps between beats (valid low) are allowed.
- FILL, one cycle: fill_we=1, fill_addr = line-aligned address, fill_data = buffer.
  - If is_st: word at offset addr[log2(LINE_WORDS)+1:2] is replaced by st_data. Merge is full-word; addr[1:0] is ignored.
  - Next state DONE.
- DONE, one cycle: repair_complete=1, repair_idx=latched idx; next state IDLE.
- Minimum latency, with request accepted at cycle T and mem_req_ready=1 at T+1:
  - mem_req_valid first high at T+1.
  - With beats at T+2..T+1+LINE_WORDS, fill_we rises at T+2+LINE_WORDS and repair_complete one cycle later.
  - repair_req_ready returns the cycle after repair_complete.
- Only one outstanding repair. No back-to-back accept in DONE; ready is asserted only in IDLE.
- mem_resp_valid outside RECV is a protocol violation: ignored; the bench flags it with an assertion.
- Counter wraps to 0 on leaving RECV. Width is log2(LINE_WORDS) bits.
- Reset mid-operation aborts the repair: no fill_we, no repair_complete. The MSHR is reset by the same rst.

Decomposition:
- cache_pkg: LINE_WORDS, WORD_OFF_W, LINE_OFF_W localparams; repair_state_e enum; repair_req_t struct (addr, is_st, st_data, idx).
- One sub-module, line_fill_buffer: LINE_WORDS×DATA_W register with beat write port and store-merge output mux.
- FSM stays in miss_repair_engine.

Test Plan:
- Load miss, addr 0x0000_1234, idx 2, mem_req_ready=1, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> mem_req_addr=0x0000_1230; fill_data={A3,A2,A1,A0} at T+6; repair_complete with repair_idx=2 at T+7.
- Store miss, addr 0x0000_2008, st_data 0xDEADBEEF, beats 0,1,2,3 -> fill_data word2=0xDEADBEEF, words 0,1,3 = 0,1,3.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable throughout; no fill until the handshake completes.
- Beats with gaps (valid pattern 1,0,0,1,1,0,1) -> buffer words written in order; fill_we exactly once.
- rst asserted asynchronously during RECV after 2 beats -> outputs 0 immediately, repair_req_ready=1; stray later beats produce no fill_we and no repair_complete.
- Second request held valid during DONE -> accepted only in IDLE, the cycle after repair_complete; no lost or duplicated request.
